// File: rtl/spi_word_reader_pkg.sv
// Shared constants, FSM encoding and default sizing for the SPI word reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_word_reader_pkg;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } spiState_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock divider: sck toggles every CLK_DIV clks while enabled, idles low.
// Latency: first rise CLK_DIV clks after en goes high; strobes flag the clk whose edge moves sck.
// Backpressure: none; dropping en forces sck low and restarts the divider.
module spi_sck_gen
  import spi_word_reader_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic sckRise,
  output logic sckFall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] divCnt;
  logic          wrap;

  // Strobes are high in the clk whose closing edge toggles sck.
  assign wrap    = en && (divCnt == DIV_LAST);
  assign sckRise = wrap && (sck == LOW);
  assign sckFall = wrap && (sck == HIGH);

  // Divider counter and sck register; sck only moves on a wrap, so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt <= '0;
      sck    <= LOW;
    end else if (!en) begin
      divCnt <= '0;
      sck    <= LOW;
    end else if (wrap) begin
      divCnt <= '0;
      sck    <= ~sck;
    end else begin
      divCnt <= divCnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_word_reader.sv
// SPI initiator: presents an address, shifts it out on mosi, reads one DATA_W word from miso.
// Latency: start to rd_valid is 2*CLK_DIV*(1+ADDR_W+DATA_W)+1 clks, fixed.
// Backpressure: none; start is ignored (not queued) while busy.
module spi_word_reader
  import spi_word_reader_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] addr_o,
  output logic              sck,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW  = $clog2(maxInt(ADDR_W, DATA_W)) + 1;
  localparam int DCW = $clog2(CLK_DIV);
  localparam logic [BW-1:0]  ADDR_LAST = BW'(ADDR_W - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_W - 1);
  localparam logic [DCW-1:0] DONE_LAST = DCW'(CLK_DIV - 1);

  spiState_t         state, nextState;
  logic              sckEn, sckRise, sckFall;
  logic              loadRose;
  logic [BW-1:0]     bitCnt;
  logic [DCW-1:0]    doneCnt;
  logic [ADDR_W-1:0] addrShift;
  logic [DATA_W-1:0] rdShift;
  logic              addrLast, dataLast;

  // LOAD runs one full sck period (low half, then the capture rise with ss high);
  // its closing fall coincides with ss dropping, which starts the mosi setup half-period.
  assign sckEn    = (state == LOAD) || (state == ADDR) || (state == DATA);
  assign addrLast = (state == ADDR) && sckFall && (bitCnt == ADDR_LAST);
  assign dataLast = (state == DATA) && sckFall && (bitCnt == DATA_LAST);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) sckGen (
    .clk     (clk),
    .rst     (rst),
    .en      (sckEn),
    .sck     (sck),
    .sckRise (sckRise),
    .sckFall (sckFall)
  );

  // FSM state register; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic plus the select, busy and mosi outputs.
  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    ss        = HIGH;
    mosi      = LOW;
    case (state)
      IDLE: if (start) nextState = LOAD;
      LOAD: if (sckFall && loadRose) nextState = ADDR;
      ADDR: begin
        ss   = LOW;
        mosi = addrShift[ADDR_W-1];
        if (addrLast) nextState = DATA;
      end
      DATA: begin
        ss = LOW;
        if (dataLast) nextState = DONE;
      end
      DONE: if (doneCnt == DONE_LAST) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Address latch, bit/gap counters, shift registers and the output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_o    <= '0;
      addrShift <= '0;
      rdShift   <= '0;
      rd_data   <= '0;
      rd_valid  <= LOW;
      bitCnt    <= '0;
      doneCnt   <= '0;
      loadRose  <= LOW;
    end else begin
      rd_valid <= LOW;
      case (state)
        IDLE: begin
          if (start) begin
            addr_o   <= addr_in;
            loadRose <= LOW;
          end
        end
        LOAD: begin
          if (sckRise) loadRose <= HIGH;
          if (sckFall && loadRose) begin
            addrShift <= addr_o;
            bitCnt    <= '0;
          end
        end
        ADDR: begin
          if (sckFall) begin
            if (addrLast) begin
              bitCnt <= '0;
            end else begin
              bitCnt    <= bitCnt + BW'(1);
              addrShift <= {addrShift[ADDR_W-2:0], LOW};
            end
          end
        end
        DATA: begin
          if (sckFall) begin
            rdShift <= {rdShift[DATA_W-2:0], miso};
            if (dataLast) begin
              rd_data  <= {rdShift[DATA_W-2:0], miso};
              rd_valid <= HIGH;
              bitCnt   <= '0;
              doneCnt  <= '0;
            end else begin
              bitCnt <= bitCnt + BW'(1);
            end
          end
        end
        DONE: doneCnt <= (doneCnt == DONE_LAST) ? '0 : doneCnt + DCW'(1);
        default: ;
      endcase
    end
  end

endmodule
